fp_addsub_arbiter: RTL and testbench
====================================

Name: fp_addsub_arbiter

Overview:
- Shares one combinational add_sub unit (IEEE-754 single precision, A ± B) between NREQ requesters in the Nroot datapath. Typical requesters: iteration update, error estimate, final correction.
- Arbitrates round-robin, latches the winner's operands, registers the add_sub result and flags, and returns them with a one-cycle done pulse to the granted requester.
- Sits between the Nroot sequencing FSMs and the single add_sub instance, which it contains.

Parameters:
NREQ, 4, number of requesters (legal 2..8)
IDX_W, 2, width of requester index; must equal ceil(log2(NREQ))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; bit i held high until done[i]
op_a  input  32*NREQ  operand A of requester i in bits [32i+31:32i]
op_b  input  32*NREQ  operand B of requester i in bits [32i+31:32i]
op_sub  input  NREQ  per-requester operation select: 0 = A+B, 1 = A−B
grant  output  NREQ  one-hot; bit of the current owner, high in EXEC and RESP
done  output  NREQ  one-hot, one-cycle pulse to the owner when result is valid
result  output  32  registered IEEE-754 result of the last completed operation
overflow  output  1  registered add_sub overflow flag of the last operation
underflow  output  1  registered add_sub underflow flag of the last operation
busy  output  1  high in EXEC and RESP

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, done=0, result=32'h0, overflow=0, underflow=0, busy=0, owner=0, rr_ptr=NREQ-1, so requester 0 has first priority.
- Internal: one add_sub instance fed from latched regs a_q, b_q, sub_q. Nothing combinational from req or op_* reaches the outputs.
- FSM, 3 states:
  - IDLE: if req≠0, pick the first set bit scanning from rr_ptr+1 upward, wrapping modulo NREQ. Latch a_q, b_q, sub_q and owner from that requester, then go to EXEC. If req=0, stay in IDLE and hold all registers.
  - EXEC: grant[owner]=1, busy=1. At the clock edge, capture add_sub result/overflow/underflow into result/overflow/underflow. Go to RESP.
  - RESP: done[owner]=1 for exactly this cycle, grant held, busy=1. At the edge, rr_ptr←owner and go to IDLE.
- Latency: req sampled high in IDLE at edge 0 → grant from edge 0 → result and flags valid and done high from edge 1 to edge 2. Each operation takes 3 cycles including IDLE. Max throughput is one op per 3 cycles.
- result/overflow/underflow stay stable from capture until the next EXEC capture. They remain readable after done falls.
- Operands are sampled only in the IDLE-to-EXEC cycle. Operand changes after that have no effect on the operation in flight.
- Requester handshake: deassert req[i] in the cycle after seeing done[i]. If req[i] is still high when IDLE is re-entered, it is a new request, arbitrated normally (it has lowest priority because rr_ptr=i).
- req dropping while its operation is in EXEC/RESP: the operation still completes and done still pulses. Simultaneous requests never cause a double grant.
- Zero/special values: the arbiter passes the add_sub output unchanged. Flags are exactly the add_sub flags.
- rst asserted in EXEC or RESP aborts the operation: no done pulse, state and outputs go to their reset values immediately. The pending request is re-arbitrated after rst falls.
- grant and done are always one-hot or zero. done is a subset of grant.

Test Plan:
- Single op: req=4'b0001, A=0x3F800000, B=0x40000000, sub=0 → grant=0001 next cycle; done[0] pulses one cycle later; result=0x40400000, overflow=0, underflow=0.
- Subtract: requester 2, A=0x40A00000, B=0x40400000, sub=1 → done=0100, result=0x40000000.
- Round-robin: req=4'b1111 held from reset; each requester deasserts after its done → done order 0,1,2,3, pulses 3 cycles apart, no gaps or double grants. Repeat with req[0] held high continuously → order 0,1,2,3,0.
- Overflow: A=B=0x7F7FFFFF, sub=0 → overflow=1 with done. Results hold after done until the next op.
- Operand stability: change op_a of the owner during EXEC → result matches the originally sampled operands.
- Reset mid-op: assert rst during EXEC → grant, done, busy, result=0 immediately, no done pulse. After rst release with req[1] high → requester 1 served normally.

Source files
------------

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter that shares one combinational single-precision add/sub unit
// among NREQ requesters. The winner's operands are latched, and the result is registered.

module fp_addsub_unit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);
    // Denormal inputs are read as signed zero. Results below the normal range flush
    // to signed zero and raise underflow. Rounding is round-to-nearest-even.

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       hit;
        cnt = 5'd27;
        hit = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!hit && v[i]) begin
                cnt = 5'(26 - i);
                hit = 1'b1;
            end
        end
        return cnt;
    endfunction

    function automatic logic [33:0] round_pack(input logic sign,
                                               input logic signed [9:0] exp_in,
                                               input logic [26:0] sig);
        logic              up;
        logic [24:0]       m;
        logic signed [9:0] e;
        logic [33:0]       r;
        up = sig[2] & (sig[1] | sig[0] | sig[3]);
        m  = {1'b0, sig[26:3]} + {24'd0, up};
        e  = exp_in;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e <= 10'sd0)
            r = {2'b01, sign, 31'd0};
        else if (e >= 10'sd255)
            r = {2'b10, sign, 8'hFF, 23'd0};
        else
            r = {2'b00, sign, e[7:0], m[22:0]};
        return r;
    endfunction

    logic [7:0]        ea, eb, el, es, d;
    logic [22:0]       ma, mb, ml, ms;
    logic              sa, sb, sl, ss;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big;
    logic [4:0]        dd, lz;
    logic [53:0]       wide;
    logic [26:0]       sig_l, sig_s, norm;
    logic [27:0]       sum;
    logic signed [9:0] exp_n;
    logic [33:0]       packed_r;

    always_comb begin
        sa = a[31];
        ea = a[30:23];
        ma = a[22:0];
        sb = b[31] ^ sub;
        eb = b[30:23];
        mb = b[22:0];
        nan_a  = (&ea) & (|ma);
        nan_b  = (&eb) & (|mb);
        inf_a  = (&ea) & ~(|ma);
        inf_b  = (&eb) & ~(|mb);
        zero_a = ~(|ea);
        zero_b = ~(|eb);

        a_big = {ea, ma} >= {eb, mb};
        el = a_big ? ea : eb;
        es = a_big ? eb : ea;
        ml = a_big ? ma : mb;
        ms = a_big ? mb : ma;
        sl = a_big ? sa : sb;
        ss = a_big ? sb : sa;

        // Three guard bits plus a sticky bit collected from everything shifted out.
        d     = el - es;
        dd    = (d > 8'd27) ? 5'd27 : d[4:0];
        sig_l = {1'b1, ml, 3'b000};
        wide  = {1'b1, ms, 3'b000, 27'd0} >> dd;
        sig_s = wide[53:27] | {26'd0, |wide[26:0]};
        sum   = (sl == ss) ? ({1'b0, sig_l} + {1'b0, sig_s})
                           : ({1'b0, sig_l} - {1'b0, sig_s});

        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, el}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, el}) - $signed({5'd0, lz});
        end
        packed_r = round_pack(sl, exp_n, norm);

        result    = packed_r[31:0];
        overflow  = packed_r[33];
        underflow = packed_r[32];
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            result    = 32'h7FC0_0000;
            overflow  = 1'b0;
            underflow = 1'b0;
        end else if (inf_a) begin
            result    = {sa, 8'hFF, 23'd0};
            overflow  = 1'b0;
            underflow = 1'b0;
        end else if (inf_b) begin
            result    = {sb, 8'hFF, 23'd0};
            overflow  = 1'b0;
            underflow = 1'b0;
        end else if (zero_a && zero_b) begin
            result    = {sa & sb, 31'd0};
            overflow  = 1'b0;
            underflow = 1'b0;
        end else if (zero_a) begin
            result    = {sb, b[30:0]};
            overflow  = 1'b0;
            underflow = 1'b0;
        end else if (zero_b) begin
            result    = a;
            overflow  = 1'b0;
            underflow = 1'b0;
        end else if (sum == 28'd0) begin
            result    = 32'd0;
            overflow  = 1'b0;
            underflow = 1'b0;
        end
    end
endmodule

module fp_addsub_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   op_a,
    input  logic [32*NREQ-1:0]   op_b,
    input  logic [NREQ-1:0]      op_sub,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d, rr_q, rr_d, pick, cand;
    logic             found;
    logic [NREQ-1:0]  grant_q, grant_d, done_q, done_d;
    logic             busy_q, busy_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [31:0]      result_q, result_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d;
    logic [31:0]      as_result;
    logic             as_ovf, as_unf;

    fp_addsub_unit u_addsub (
        .a         (a_q),
        .b         (b_q),
        .sub       (sub_q),
        .result    (as_result),
        .overflow  (as_ovf),
        .underflow (as_unf)
    );

    // The scan starts just after the last owner, so that owner has the lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = EXEC;
                    owner_d = pick;
                    grant_d = NREQ'(1) << pick;
                    busy_d  = 1'b1;
                    a_d     = op_a[32*pick +: 32];
                    b_d     = op_b[32*pick +: 32];
                    sub_d   = op_sub[pick];
                end
            end
            EXEC: begin
                state_d  = RESP;
                result_d = as_result;
                ovf_d    = as_ovf;
                unf_d    = as_unf;
                done_d   = grant_q;
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = owner_q;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= IDX_W'(NREQ - 1);
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sub_q <= sub_d;
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter. The reference adds in double precision and rounds the result to single precision,
// flushing tiny results to zero. Arbitration order is derived from the round-robin rule.

module tb_fp_addsub_arbiter;
    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req, op_sub, grant, done;
    logic [32*NREQ-1:0]  op_a, op_b;
    logic [31:0]         result;
    logic                overflow, underflow, busy;
    int                  checks = 0;
    int                  failures = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .grant(grant), .done(done), .result(result), .overflow(overflow),
        .underflow(underflow), .busy(busy)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)
            d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF)
            d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else
            d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {overflow, underflow, result}.
    function automatic logic [33:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] q;
        logic [28:0] rem;
        logic [33:0] o;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF)
            o = (d[51:0] != 52'd0) ? {2'b00, 32'h7FC0_0000} : {2'b00, d[63], 8'hFF, 23'd0};
        else if (d[62:52] == 11'd0)
            o = {2'b00, d[63], 31'd0};
        else begin
            e   = int'(d[62:52]) - 1023;
            q   = {2'b01, d[51:29]};
            rem = d[28:0];
            if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && q[0])) q = q + 25'd1;
            if (q[24]) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e < -126)     o = {2'b01, d[63], 31'd0};
            else if (e > 127) o = {2'b10, d[63], 8'hFF, 23'd0};
            else              o = {2'b00, d[63], 8'(e + 127), q[22:0]};
        end
        return o;
    endfunction

    function automatic logic [33:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic s);
        real x, y;
        x = f2r(a);
        y = f2r(b);
        return r2f(s ? (x - y) : (x + y));
    endfunction

    function automatic logic [31:0] rand_near(input logic [7:0] base);
        logic [31:0] r, r2;
        int          e;
        r  = $urandom();
        r2 = $urandom();
        if (r[30:28] == 3'd0) return r2;
        e = int'(base) + int'(r[27:23]) - 16;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {r[31], 8'(e), r2[22:0]};
    endfunction

    task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
        logic [7:0]  base;
        logic [31:0] r;
        base = 8'($urandom_range(1, 254));
        a = rand_near(base);
        b = rand_near(base);
        r = $urandom();
        if (r[1:0] == 2'd0) b = {r[31], a[30:23], a[22:0] ^ {15'd0, r[9:2]}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc, output logic to);
        cyc = 0;
        to  = 1'b1;
        while (to && cyc < budget) begin
            tick();
            cyc++;
            if (done != '0) to = 1'b0;
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        op_a[32*i +: 32] = a;
        op_b[32*i +: 32] = b;
        op_sub[i]        = s;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (grant !== '0)     begin failures++; $display("FAIL reset_grant got=%b want=0", grant); end
        checks++; if (done !== '0)      begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b want=00", {overflow, underflow}); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || grant !== '0) begin failures++; $display("FAIL idle_no_req busy=%b grant=%b want 0", busy, grant); end
    endtask

    task automatic test_single_op();
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001 || busy !== 1'b1 || done !== '0) begin failures++; $display("FAIL single_exec grant=%b busy=%b done=%b want 0001/1/0000", grant, busy, done); end
        tick();
        checks++; if (done !== 4'b0001 || grant !== 4'b0001) begin failures++; $display("FAIL single_done done=%b grant=%b want 0001/0001", done, grant); end
        checks++; if (result !== 32'h4040_0000) begin failures++; $display("FAIL single_result got=%h want=40400000", result); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL single_flags got=%b want=00", {overflow, underflow}); end
        req = '0;
        tick();
        checks++; if (done !== '0 || grant !== '0 || busy !== 1'b0) begin failures++; $display("FAIL single_after done=%b grant=%b busy=%b want 0", done, grant, busy); end
        checks++; if (result !== 32'h4040_0000) begin failures++; $display("FAIL single_hold got=%h want=40400000", result); end
    endtask

    task automatic test_overflow();
        int   cyc;
        logic to;
        set_op(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
        req = 4'b0010;
        wait_done(8, cyc, to);
        checks++; if (to || done !== 4'b0010) begin failures++; $display("FAIL ovf_done got=%b want=0010", done); end
        checks++; if ({overflow, underflow, result} !== {2'b10, 32'h7F80_0000}) begin failures++; $display("FAIL ovf_result got=%b%b_%h want=10_7f800000", overflow, underflow, result); end
        req = '0;
        tick(); tick(); tick();
        checks++; if (overflow !== 1'b1 || result !== 32'h7F80_0000 || busy !== 1'b0) begin failures++; $display("FAIL ovf_hold ovf=%b result=%h busy=%b want 1/7f800000/0", overflow, result, busy); end
    endtask

    task automatic test_subtract();
        int   cyc;
        logic to;
        set_op(2, 32'h40A0_0000, 32'h4040_0000, 1'b1);
        req = 4'b0100;
        wait_done(8, cyc, to);
        checks++; if (to || done !== 4'b0100 || grant !== 4'b0100) begin failures++; $display("FAIL sub_done done=%b grant=%b want 0100", done, grant); end
        checks++; if (result !== 32'h4000_0000 || overflow !== 1'b0) begin failures++; $display("FAIL sub_result got=%h ovf=%b want=40000000/0", result, overflow); end
        req = '0;
        tick();
    endtask

    task automatic test_operand_stability();
        int   cyc;
        logic to;
        set_op(3, 32'h4120_0000, 32'h3F80_0000, 1'b1);
        req = 4'b1000;
        tick();
        set_op(3, 32'h42C8_0000, 32'h0000_0000, 1'b0);
        wait_done(4, cyc, to);
        checks++; if (to || done !== 4'b1000 || cyc != 1) begin failures++; $display("FAIL stab_done done=%b cyc=%0d want 1000/1", done, cyc); end
        checks++; if (result !== 32'h4110_0000) begin failures++; $display("FAIL stab_result got=%h want=41100000", result); end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin(input logic hold0, input int n_exp);
        int          exp_order[5] = '{0, 1, 2, 3, 0};
        logic [31:0] ta[NREQ];
        logic [31:0] tbv[NREQ];
        logic        ts[NREQ];
        logic [33:0] want;
        int          served, last_t, t, idx;
        if (!hold0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            gen_pair(ta[i], tbv[i]);
            ts[i] = 1'($urandom_range(0, 1));
            set_op(i, ta[i], tbv[i], ts[i]);
        end
        req = '1;
        served = 0; last_t = 0; t = 0;
        while (served < n_exp && t < 60) begin
            tick();
            t++;
            checks++;
            if ($countones(grant) > 1 || (done & ~grant) != '0) begin failures++; $display("FAIL rr_onehot grant=%b done=%b", grant, done); end
            if (done != '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
                checks++; if (done !== (NREQ'(1) << exp_order[served])) begin failures++; $display("FAIL rr_order n=%0d got=%b want_idx=%0d", served, done, exp_order[served]); end
                want = ref_addsub(ta[idx], tbv[idx], ts[idx]);
                checks++; if ({overflow, underflow, result} !== want) begin failures++; $display("FAIL rr_result idx=%0d got=%b%b_%h want=%b_%h", idx, overflow, underflow, result, want[33:32], want[31:0]); end
                if (served > 0) begin
                    checks++; if (t - last_t != 3) begin failures++; $display("FAIL rr_gap got=%0d want=3", t - last_t); end
                end
                last_t = t;
                served++;
                if (!(hold0 && idx == 0)) req[idx] = 1'b0;
            end
        end
        checks++; if (served != n_exp) begin failures++; $display("FAIL rr_count got=%0d want=%0d", served, n_exp); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random(input int n);
        logic [31:0]     ta[NREQ];
        logic [31:0]     tbv[NREQ];
        logic            ts[NREQ];
        logic [NREQ-1:0] mask;
        logic [33:0]     want;
        int              rr_m, w, cyc;
        logic            to;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_m = NREQ - 1;
        for (int it = 0; it < n; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                gen_pair(ta[i], tbv[i]);
                ts[i] = 1'($urandom_range(0, 1));
                set_op(i, ta[i], tbv[i], ts[i]);
            end
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && mask[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
            req = mask;
            wait_done(8, cyc, to);
            checks++; if (to || cyc != 2) begin failures++; $display("FAIL rand_latency it=%0d cyc=%0d timeout=%b want 2", it, cyc, to); end
            checks++; if (done !== (NREQ'(1) << w) || grant !== done) begin failures++; $display("FAIL rand_winner it=%0d mask=%b done=%b grant=%b want_idx=%0d", it, mask, done, grant, w); end
            want = ref_addsub(ta[w], tbv[w], ts[w]);
            checks++; if ({overflow, underflow, result} !== want) begin failures++; $display("FAIL rand_result it=%0d a=%h b=%h sub=%b got=%b%b_%h want=%b_%h", it, ta[w], tbv[w], ts[w], overflow, underflow, result, want[33:32], want[31:0]); end
            rr_m = w;
            req = '0;
            tick();
            checks++; if (busy !== 1'b0 || done !== '0) begin failures++; $display("FAIL rand_idle busy=%b done=%b want 0", busy, done); end
        end
    endtask

    task automatic test_reset_mid_op();
        int   cyc;
        logic to;
        set_op(1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rst_mid_exec grant=%b want=0010", grant); end
        rst = 1'b1;
        #1;
        checks++; if (grant !== '0 || done !== '0 || busy !== 1'b0 || result !== 32'd0) begin failures++; $display("FAIL rst_mid_clear grant=%b done=%b busy=%b result=%h want 0", grant, done, busy, result); end
        tick();
        checks++; if (done !== '0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_nodone done=%b busy=%b want 0", done, busy); end
        rst = 1'b0;
        wait_done(8, cyc, to);
        checks++; if (to || done !== 4'b0010 || cyc != 2) begin failures++; $display("FAIL rst_mid_serve done=%b cyc=%0d want 0010/2", done, cyc); end
        checks++; if (result !== 32'h4040_0000) begin failures++; $display("FAIL rst_mid_result got=%h want=40400000", result); end
        req = '0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        op_a = '0;
        op_b = '0;
        op_sub = '0;
        test_reset();
        test_single_op();
        test_overflow();
        test_subtract();
        test_operand_stability();
        test_round_robin(1'b0, 4);
        test_round_robin(1'b1, 5);
        test_random(40);
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
